// File: rtl/led_pkg.sv
// ============================================================================
// led_pkg
// Shared definitions for the LED cube sequencer: the state encoding (also
// shown on the debug LEDs) and the default sizing constants.
//
// No ports (package).
//
// Optional feature macro used by the top: IDLE_TIMEOUT_EN
// ============================================================================
package led_pkg;

   // State codes are fixed because the debug LEDs display them directly.
   typedef enum logic [3:0] {
      S_OFF   = 4'd0,
      S_CDA   = 4'd1,
      S_WPOS  = 4'd2,
      S_LPOS  = 4'd3,
      S_WCOL  = 4'd4,
      S_LCOL  = 4'd5,
      S_CHK   = 4'd6,
      S_ANIM  = 4'd7,
      S_PAUSE = 4'd8
   } state_t;

   localparam int DEF_MAX_VOX     = 8;
   localparam int DEF_TIMEOUT_CYC = 50000000;
   localparam int IDLE_W          = 26;

endpackage

// File: rtl/key_edge.sv
// ============================================================================
// key_edge
// Rising-edge detector for one debounced, already-synchronous key level.
// The previous level is held in a single register. The pulse is high for the
// one cycle in which the key is high but was low at the previous clock, so a
// held key produces exactly one pulse.
//
// Ports:
//   clk      in  1  system clock
//   reset    in  1  asynchronous active-high reset (clears the history bit)
//   i_key    in  1  key level
//   o_pulse  out 1  one-cycle rising-edge pulse
// ============================================================================
module key_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_key,
   output logic o_pulse
);

   logic r_prev;

   // Remember last cycle's key level. Clearing it on reset means a key that
   // is already held when reset is released still counts as one press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_key;
      end
   end

   assign o_pulse = i_key & ~r_prev;

endmodule

// File: rtl/led_seq_ctrl.sv
// ============================================================================
// led_seq_ctrl
// Top-level sequencer for the LED cube datapath. Turns key presses into the
// datapath control strobes. The flow is countdown, then position/colour
// entry per voxel, then animation with pause.
//
// Optional feature macro: IDLE_TIMEOUT_EN
//   When defined, an idle counter in the two wait states returns the block
//   to S_OFF after TIMEOUT_CYC quiet cycles and pulses 'timeout'.
//   When undefined, the wait states hold forever and 'timeout' is 0.
//
// Parameters:
//   MAX_VOX      voxels accepted before entry locks (1..255)
//   TIMEOUT_CYC  idle cycles before auto-return (IDLE_TIMEOUT_EN only)
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   go_key, anim_key,
//   pause_key, clear_key       debounced key levels (rising edge = event)
//   cda_done                   countdown finished
//   rcm                        datapath rejected the colour
//   off,cda,pos,cho_c,ans,
//   pause,load                 datapath strobes, decoded from the state
//   state [3:0]                current state code
//   vox_cnt [7:0]              voxels committed so far
//   timeout                    one-cycle idle timeout pulse
// ============================================================================
module led_seq_ctrl
   import led_pkg::*;
#(
   parameter int MAX_VOX     = DEF_MAX_VOX,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go_key,
   input  logic       anim_key,
   input  logic       pause_key,
   input  logic       clear_key,
   input  logic       cda_done,
   input  logic       rcm,
   output logic       off,
   output logic       cda,
   output logic       pos,
   output logic       cho_c,
   output logic       ans,
   output logic       pause,
   output logic       load,
   output logic [3:0] state,
   output logic [7:0] vox_cnt,
   output logic       timeout
);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_vox;
   logic       w_commit;
   logic       w_clrVox;
   logic       w_goEv;
   logic       w_animEv;
   logic       w_pauseEv;
   logic       w_clearEv;

   // One edge detector per key; every FSM decision works on events only.
   key_edge uGoEdge    (.clk(clk), .reset(reset), .i_key(go_key),    .o_pulse(w_goEv));
   key_edge uAnimEdge  (.clk(clk), .reset(reset), .i_key(anim_key),  .o_pulse(w_animEv));
   key_edge uPauseEdge (.clk(clk), .reset(reset), .i_key(pause_key), .o_pulse(w_pauseEv));
   key_edge uClearEdge (.clk(clk), .reset(reset), .i_key(clear_key), .o_pulse(w_clearEv));

`ifdef IDLE_TIMEOUT_EN
   logic [IDLE_W-1:0] r_idle;
   logic              r_timeout;
   logic              w_inWait;
   logic              w_anyEv;
   logic              w_idleHit;

   assign w_inWait  = (r_state == S_WPOS) || (r_state == S_WCOL);
   assign w_anyEv   = w_goEv | w_animEv | w_pauseEv | w_clearEv;
   assign w_idleHit = w_inWait && !w_anyEv && (r_idle == IDLE_W'(TIMEOUT_CYC - 1));

   // Idle counter only advances while sitting quietly in a wait state; any
   // key press or state change restarts it. The timeout pulse is registered
   // so it lines up with the first cycle back in S_OFF.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_idleHit;
         if (!w_inWait || w_anyEv || (w_next != r_state)) begin
            r_idle <= '0;
         end else begin
            r_idle <= r_idle + 1'b1;
         end
      end
   end

   assign timeout = r_timeout;
`else
   logic w_unusedTimeoutCfg;
   assign w_unusedTimeoutCfg = (TIMEOUT_CYC > 0);
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_OFF;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic. Clear is applied last so that it overrides any other
   // event seen in the same cycle; in S_OFF it has nothing to abort.
   always_comb begin
      w_next   = r_state;
      w_commit = 1'b0;
      w_clrVox = 1'b0;
      case (r_state)
         S_OFF:   if (w_goEv) w_next = S_CDA;
         S_CDA:   if (cda_done) w_next = S_WPOS;
         S_WPOS: begin
            if (w_animEv && (r_vox != 8'd0)) begin
               w_next = S_ANIM;
            end else if (w_goEv && (r_vox < 8'(MAX_VOX))) begin
               w_next = S_LPOS;
            end
         end
         S_LPOS:  w_next = S_WCOL;
         S_WCOL:  if (w_goEv) w_next = S_LCOL;
         S_LCOL:  w_next = S_CHK;
         S_CHK: begin
            if (rcm) begin
               w_next = S_WCOL;
            end else begin
               w_commit = 1'b1;
               w_next   = S_WPOS;
            end
         end
         S_ANIM:  if (w_pauseEv) w_next = S_PAUSE;
         S_PAUSE: if (w_pauseEv) w_next = S_ANIM;
         default: w_next = S_OFF;
      endcase
`ifdef IDLE_TIMEOUT_EN
      if (w_idleHit) begin
         w_next   = S_OFF;
         w_clrVox = 1'b1;
      end
`endif
      if (w_clearEv && (r_state != S_OFF)) begin
         w_next   = S_OFF;
         w_commit = 1'b0;
         w_clrVox = 1'b1;
      end
   end

   // Voxel counter: saturates at MAX_VOX, cleared by abort or timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vox <= 8'd0;
      end else if (w_clrVox) begin
         r_vox <= 8'd0;
      end else if (w_commit && (r_vox < 8'(MAX_VOX))) begin
         r_vox <= r_vox + 8'd1;
      end
   end

   // Strobes are a pure decode of the state register.
   always_comb begin
      off   = 1'b0;
      cda   = 1'b0;
      pos   = 1'b0;
      cho_c = 1'b0;
      ans   = 1'b0;
      pause = 1'b0;
      load  = 1'b0;
      case (r_state)
         S_OFF:   off = 1'b1;
         S_CDA:   cda = 1'b1;
         S_LPOS: begin
            pos  = 1'b1;
            load = 1'b1;
         end
         S_LCOL: begin
            cho_c = 1'b1;
            load  = 1'b1;
         end
         S_ANIM:  ans = 1'b1;
         S_PAUSE: begin
            ans   = 1'b1;
            pause = 1'b1;
         end
         default: ;
      endcase
   end

   assign state   = r_state;
   assign vox_cnt = r_vox;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// ============================================================================
// tb_led_seq_ctrl
// Self-checking bench for led_seq_ctrl (MAX_VOX=2, TIMEOUT_CYC=16).
// A table of directed vectors walks the main flow, a few hand-written
// sequences cover the corner cases, then random key traffic is compared
// against a cycle model built from the sequencing rules.
// ============================================================================
module tb_led_seq_ctrl;

   localparam int MAXV = 2;
   localparam int TCYC = 16;

   localparam int ST_OFF   = 0;
   localparam int ST_CDA   = 1;
   localparam int ST_WPOS  = 2;
   localparam int ST_LPOS  = 3;
   localparam int ST_WCOL  = 4;
   localparam int ST_LCOL  = 5;
   localparam int ST_CHK   = 6;
   localparam int ST_ANIM  = 7;
   localparam int ST_PAUSE = 8;

   logic       clk;
   logic       reset;
   logic       goKey, animKey, pauseKey, clearKey, cdaDone, rcm;
   logic       off, cda, pos, choC, ans, pause, load;
   logic [3:0] state;
   logic [7:0] voxCnt;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int mState;
   int mVox;
   int mIdle;
   bit mTimeout;
   bit mPrev [4];

   typedef struct {
      bit go;
      bit anim;
      bit pse;
      bit clr;
      bit cdaDone;
      bit rcm;
      int expState;
      int expVox;
   } vec_t;

   vec_t vecs [31];

   led_seq_ctrl #(.MAX_VOX(MAXV), .TIMEOUT_CYC(TCYC)) dut (
      .clk(clk), .reset(reset),
      .go_key(goKey), .anim_key(animKey), .pause_key(pauseKey), .clear_key(clearKey),
      .cda_done(cdaDone), .rcm(rcm),
      .off(off), .cda(cda), .pos(pos), .cho_c(choC), .ans(ans), .pause(pause), .load(load),
      .state(state), .vox_cnt(voxCnt), .timeout(timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected strobe vector {off,cda,pos,cho_c,ans,pause,load} for a state.
   function automatic logic [6:0] expStrobes(input int s);
      logic [6:0] v;
      v = 7'b0;
      v[6] = (s == ST_OFF);
      v[5] = (s == ST_CDA);
      v[4] = (s == ST_LPOS);
      v[3] = (s == ST_LCOL);
      v[2] = (s == ST_ANIM) || (s == ST_PAUSE);
      v[1] = (s == ST_PAUSE);
      v[0] = (s == ST_LPOS) || (s == ST_LCOL);
      return v;
   endfunction

   task automatic modelReset();
      mState   = ST_OFF;
      mVox     = 0;
      mIdle    = 0;
      mTimeout = 0;
      for (int k = 0; k < 4; k++) mPrev[k] = 0;
   endtask

   // One clock of the sequencing rules, given the inputs present at the edge.
   task automatic modelStep(input bit g, input bit a, input bit p, input bit c,
                            input bit cd, input bit r);
      bit evG, evA, evP, evC, anyEv, idleHit;
      int nxt;
      evG = g & !mPrev[0];
      evA = a & !mPrev[1];
      evP = p & !mPrev[2];
      evC = c & !mPrev[3];
      mPrev[0] = g; mPrev[1] = a; mPrev[2] = p; mPrev[3] = c;
      anyEv = evG | evA | evP | evC;
      idleHit = 0;
`ifdef IDLE_TIMEOUT_EN
      idleHit = (mState == ST_WPOS || mState == ST_WCOL) && !anyEv && (mIdle == TCYC - 1);
`endif
      nxt = mState;
      if (evC && mState != ST_OFF) begin
         nxt  = ST_OFF;
         mVox = 0;
      end else if (idleHit) begin
         nxt  = ST_OFF;
         mVox = 0;
      end else begin
         if (mState == ST_OFF) begin
            if (evG) nxt = ST_CDA;
         end else if (mState == ST_CDA) begin
            if (cd) nxt = ST_WPOS;
         end else if (mState == ST_WPOS) begin
            if (evA && mVox > 0) nxt = ST_ANIM;
            else if (evG && mVox < MAXV) nxt = ST_LPOS;
         end else if (mState == ST_LPOS) begin
            nxt = ST_WCOL;
         end else if (mState == ST_WCOL) begin
            if (evG) nxt = ST_LCOL;
         end else if (mState == ST_LCOL) begin
            nxt = ST_CHK;
         end else if (mState == ST_CHK) begin
            if (r) nxt = ST_WCOL;
            else begin
               mVox = (mVox + 1 > MAXV) ? MAXV : mVox + 1;
               nxt  = ST_WPOS;
            end
         end else if (mState == ST_ANIM) begin
            if (evP) nxt = ST_PAUSE;
         end else if (mState == ST_PAUSE) begin
            if (evP) nxt = ST_ANIM;
         end else begin
            nxt = ST_OFF;
         end
      end
`ifdef IDLE_TIMEOUT_EN
      if ((mState == ST_WPOS || mState == ST_WCOL) && !anyEv && nxt == mState) mIdle = mIdle + 1;
      else mIdle = 0;
`endif
      mTimeout = idleHit;
      mState   = nxt;
   endtask

   task automatic checkOutput(input string tag);
      logic [6:0] gotS, wantS;
      gotS  = {off, cda, pos, choC, ans, pause, load};
      wantS = expStrobes(mState);
      checks++;
      if (int'(state) != mState) begin
         errors++;
         $display("[TB] FAIL %s state got %0d want %0d", tag, state, mState);
      end
      checks++;
      if (int'(voxCnt) != mVox) begin
         errors++;
         $display("[TB] FAIL %s vox_cnt got %0d want %0d", tag, voxCnt, mVox);
      end
      checks++;
      if (gotS !== wantS) begin
         errors++;
         $display("[TB] FAIL %s strobes got %b want %b", tag, gotS, wantS);
      end
      checks++;
      if (timeout !== mTimeout) begin
         errors++;
         $display("[TB] FAIL %s timeout got %b want %b", tag, timeout, mTimeout);
      end
   endtask

   // Drive inputs between edges, clock once, advance the model, then check.
   task automatic applyStimulus(input bit g, input bit a, input bit p, input bit c,
                                input bit cd, input bit r, input string tag);
      goKey = g; animKey = a; pauseKey = p; clearKey = c; cdaDone = cd; rcm = r;
      @(posedge clk);
      modelStep(g, a, p, c, cd, r);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      string tag;
      // Directed walk: countdown, commit, reject/recommit, saturation,
      // animation with pause (including a held pause key), then clear.
      vecs[0]  = '{1,0,0,0,0,0, ST_CDA,   0};
      vecs[1]  = '{0,0,0,0,0,0, ST_CDA,   0};
      vecs[2]  = '{0,0,0,0,0,0, ST_CDA,   0};
      vecs[3]  = '{0,0,0,0,1,0, ST_WPOS,  0};
      vecs[4]  = '{0,0,0,0,0,0, ST_WPOS,  0};
      vecs[5]  = '{1,0,0,0,0,0, ST_LPOS,  0};
      vecs[6]  = '{0,0,0,0,0,0, ST_WCOL,  0};
      vecs[7]  = '{1,0,0,0,0,0, ST_LCOL,  0};
      vecs[8]  = '{0,0,0,0,0,0, ST_CHK,   0};
      vecs[9]  = '{0,0,0,0,0,0, ST_WPOS,  1};
      vecs[10] = '{1,0,0,0,0,0, ST_LPOS,  1};
      vecs[11] = '{0,0,0,0,0,0, ST_WCOL,  1};
      vecs[12] = '{1,0,0,0,0,0, ST_LCOL,  1};
      vecs[13] = '{0,0,0,0,0,1, ST_CHK,   1};
      vecs[14] = '{0,0,0,0,0,1, ST_WCOL,  1};
      vecs[15] = '{1,0,0,0,0,0, ST_LCOL,  1};
      vecs[16] = '{0,0,0,0,0,0, ST_CHK,   1};
      vecs[17] = '{0,0,0,0,0,0, ST_WPOS,  2};
      vecs[18] = '{1,0,0,0,0,0, ST_WPOS,  2};
      vecs[19] = '{0,0,0,0,0,0, ST_WPOS,  2};
      vecs[20] = '{0,1,0,0,0,0, ST_ANIM,  2};
      vecs[21] = '{0,0,0,0,0,0, ST_ANIM,  2};
      vecs[22] = '{0,0,1,0,0,0, ST_PAUSE, 2};
      vecs[23] = '{0,0,1,0,0,0, ST_PAUSE, 2};
      vecs[24] = '{0,0,0,0,0,0, ST_PAUSE, 2};
      vecs[25] = '{0,0,1,0,0,0, ST_ANIM,  2};
      vecs[26] = '{0,0,0,0,0,0, ST_ANIM,  2};
      vecs[27] = '{0,0,1,0,0,0, ST_PAUSE, 2};
      vecs[28] = '{0,0,0,0,0,0, ST_PAUSE, 2};
      vecs[29] = '{0,0,0,1,0,0, ST_OFF,   0};
      vecs[30] = '{0,0,0,0,0,0, ST_OFF,   0};

      reset = 1'b1;
      goKey = 0; animKey = 0; pauseKey = 0; clearKey = 0; cdaDone = 0; rcm = 0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("inReset");
      reset = 1'b0;
      #2;
      checkOutput("afterReset");

      for (int i = 0; i < 31; i++) begin
         tag = $sformatf("vec%0d", i);
         applyStimulus(vecs[i].go, vecs[i].anim, vecs[i].pse, vecs[i].clr,
                       vecs[i].cdaDone, vecs[i].rcm, tag);
         checks++;
         if (int'(state) != vecs[i].expState || int'(voxCnt) != vecs[i].expVox) begin
            errors++;
            $display("[TB] FAIL %s table got state %0d vox %0d want state %0d vox %0d",
                     tag, state, voxCnt, vecs[i].expState, vecs[i].expVox);
         end
      end

      // Anim at zero voxels is ignored; anim beats go at one voxel.
      applyStimulus(1,0,0,0,0,0, "h5go");
      applyStimulus(0,0,0,0,1,0, "h5cda");
      applyStimulus(0,1,0,0,0,0, "h5anim0");
      checks++;
      if (int'(state) != ST_WPOS) begin
         errors++;
         $display("[TB] FAIL h5anim0 state got %0d want %0d", state, ST_WPOS);
      end
      applyStimulus(1,0,0,0,0,0, "h5pos");
      applyStimulus(0,0,0,0,0,0, "h5wcol");
      applyStimulus(1,0,0,0,0,0, "h5lcol");
      applyStimulus(0,0,0,0,0,0, "h5chk");
      applyStimulus(0,0,0,0,0,0, "h5commit");
      applyStimulus(1,1,0,0,0,0, "h5both");
      checks++;
      if (int'(state) != ST_ANIM || ans !== 1'b1) begin
         errors++;
         $display("[TB] FAIL h5both state got %0d ans %b want %0d ans 1", state, ans, ST_ANIM);
      end
      // Clear wins over a simultaneous pause.
      applyStimulus(0,0,1,1,0,0, "hClrPause");
      applyStimulus(0,0,0,0,0,0, "hIdleOff");

      // Asynchronous reset in the middle of the countdown.
      applyStimulus(1,0,0,0,0,0, "hRstGo");
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("asyncRst");
      #1;
      reset = 1'b0;
      applyStimulus(0,0,0,0,0,0, "postRst");

`ifdef IDLE_TIMEOUT_EN
      applyStimulus(1,0,0,0,0,0, "toGo");
      applyStimulus(0,0,0,0,1,0, "toCda");
      applyStimulus(1,0,0,0,0,0, "toPos");
      applyStimulus(0,0,0,0,0,0, "toWcol");
      for (int k = 0; k < TCYC; k++) applyStimulus(0,0,0,0,0,0, "toIdle");
      checks++;
      if (timeout !== 1'b1 || int'(state) != ST_OFF) begin
         errors++;
         $display("[TB] FAIL timeoutSeq got state %0d timeout %b want 0 and 1", state, timeout);
      end
`endif

      // Random key traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
